// File: rtl/sa_result_collector_pkg.sv
// Shared definitions for the systolic-array result collector:
// FSM state type, default widths and saturation bound helpers.
package sa_result_collector_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam int unsigned DEF_D_W   = 8;
  localparam int unsigned DEF_ACC_W = 24;
  localparam int unsigned DEF_X_R   = 16;
  localparam int unsigned DEF_W_C   = 16;
  localparam int unsigned DEF_SHIFT = 4;
  localparam int unsigned N_DIM_W   = 8;

  // Largest / smallest signed value representable in dw bits.
  function automatic longint sat_max(int unsigned dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(int unsigned dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

  localparam longint DEF_SAT_MAX = sat_max(DEF_D_W);
  localparam longint DEF_SAT_MIN = sat_min(DEF_D_W);

endpackage

// File: rtl/sa_result_collector_if.sv
// Handshake and result bus between the PE array drain, the collector
// and the downstream MHA stage.
interface sa_result_collector_if
  import sa_result_collector_pkg::*;
#(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned X_R   = DEF_X_R,
  parameter int unsigned W_C   = DEF_W_C
) ();

  logic               I_START;
  logic [N_DIM_W-1:0] I_N_DIM;
  logic               I_COL_VALID;
  logic [ACC_W-1:0]   I_COL_DATA [X_R];
  logic               O_COL_READY;
  logic [D_W-1:0]     O_Y_MATRIX [X_R][W_C];
  logic               O_BUSY;
  logic               O_DONE;
  logic               O_SAT_FLAG;

  modport master (
    output I_START, I_N_DIM, I_COL_VALID, I_COL_DATA,
    input  O_COL_READY, O_Y_MATRIX, O_BUSY, O_DONE, O_SAT_FLAG
  );

  modport slave (
    input  I_START, I_N_DIM, I_COL_VALID, I_COL_DATA,
    output O_COL_READY, O_Y_MATRIX, O_BUSY, O_DONE, O_SAT_FLAG
  );

endinterface

// File: rtl/sa_result_collector_quant.sv
// sa_quant: requantizes one accumulator element by arithmetic right shift
// and narrows it to D_W bits.
// Optional feature macro: SA_COLLECT_SAT_EN (saturate instead of wrap).
module sa_quant
  import sa_result_collector_pkg::*;
#(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [D_W-1:0]   val_o,
  output logic             sat_o
);

  logic signed [ACC_W-1:0] t;

  assign t = $signed(acc_i) >>> SHIFT;

`ifdef SA_COLLECT_SAT_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_max(D_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_min(D_W));

  // Clamp to the nearest representable bound and flag it.
  always_comb begin
    val_o = t[D_W-1:0];
    sat_o = 1'b0;
    if (t > HI) begin
      val_o = HI[D_W-1:0];
      sat_o = 1'b1;
    end else if (t < LO) begin
      val_o = LO[D_W-1:0];
      sat_o = 1'b1;
    end
  end
`else
  logic unused_hi;

  assign val_o     = t[D_W-1:0];
  assign sat_o     = 1'b0;
  assign unused_hi = ^t[ACC_W-1:D_W];
`endif

endmodule

// File: rtl/sa_result_collector.sv
// sa_result_collector: drains column vectors from the PE array (highest
// column index first), requantizes them and assembles the output matrix.
// Optional feature macro: SA_COLLECT_SAT_EN (see sa_quant).
module sa_result_collector
  import sa_result_collector_pkg::*;
#(
  parameter int unsigned D_W   = DEF_D_W,
  parameter int unsigned ACC_W = DEF_ACC_W,
  parameter int unsigned X_R   = DEF_X_R,
  parameter int unsigned W_C   = DEF_W_C,
  parameter int unsigned SHIFT = DEF_SHIFT
) (
  input logic                 I_CLK,
  input logic                 I_RST,
  sa_result_collector_if.slave col_if
);

  localparam int unsigned        CW   = $clog2(W_C + 1);
  localparam logic [N_DIM_W-1:0] WC_N = N_DIM_W'(W_C);

  state_t          state_q, state_d;
  logic [CW-1:0]   n_q, cnt_q;
  logic [CW-1:0]   n_start, col_idx;
  logic [D_W-1:0]  mat_q [X_R][W_C];
  logic            sat_q;
  logic            hs;
  logic            ready, busy, done;
  logic [D_W-1:0]  q_val [X_R];
  logic [X_R-1:0]  q_sat;

  assign n_start = (col_if.I_N_DIM > WC_N) ? CW'(W_C) : CW'(col_if.I_N_DIM);
  assign hs      = col_if.I_COL_VALID & (state_q == COLLECT);
  assign col_idx = n_q - cnt_q - CW'(1);

  for (genvar r = 0; r < int'(X_R); r++) begin : g_quant
    sa_quant #(
      .D_W   (D_W),
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_quant (
      .acc_i (col_if.I_COL_DATA[r]),
      .val_o (q_val[r]),
      .sat_o (q_sat[r])
    );
  end

  // State register.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/status outputs; I_START overrides every state.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: ;
      COLLECT: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (col_if.I_COL_VALID && (cnt_q == n_q - CW'(1))) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (col_if.I_START) state_d = (n_start == '0) ? DONE : COLLECT;
  end

  // Column counter, sticky saturation flag and matrix write by column index.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      n_q   <= '0;
      cnt_q <= '0;
      sat_q <= 1'b0;
      for (int unsigned r = 0; r < X_R; r++)
        for (int unsigned c = 0; c < W_C; c++)
          mat_q[r][c] <= '0;
    end else if (col_if.I_START) begin
      n_q   <= n_start;
      cnt_q <= '0;
      sat_q <= 1'b0;
      for (int unsigned r = 0; r < X_R; r++)
        for (int unsigned c = 0; c < W_C; c++)
          mat_q[r][c] <= '0;
    end else if (hs) begin
      cnt_q <= cnt_q + CW'(1);
      sat_q <= sat_q | (|q_sat);
      for (int unsigned r = 0; r < X_R; r++)
        for (int unsigned c = 0; c < W_C; c++)
          if (CW'(c) == col_idx) mat_q[r][c] <= q_val[r];
    end
  end

  assign col_if.O_COL_READY = ready;
  assign col_if.O_BUSY      = busy;
  assign col_if.O_DONE      = done;
  assign col_if.O_SAT_FLAG  = sat_q;
  assign col_if.O_Y_MATRIX  = mat_q;

endmodule

// File: doc/sa_result_collector.md
# sa_result_collector

Drain-side companion of the systolic-array input feeder: once the array has finished accumulating, this block pulls the X_R x W_C accumulator results out of the array one column per handshake, requantizes each ACC_W accumulator to D_W by arithmetic right shift, and assembles the output matrix. It sits between the PE array's column-shift output and the downstream MHA stage (softmax / next matmul operand), and reports completion with a one-cycle done pulse.

## Interface
- D_W, 8, output element width (signed)
- ACC_W, 24, PE accumulator width (signed)
- X_R, 16, array rows = elements per column vector
- W_C, 16, array columns = max columns collected
- SHIFT, 4, fixed-point right shift applied before narrowing (0..ACC_W-1)
- I_CLK  in  1  clock
- I_RST  in  1  asynchronous, active-high reset
- I_START  in  1  synchronous pulse; clears matrix/counters and begins a collection
- I_N_DIM  in  8  number of active columns to collect; sampled on I_START; values > W_C clamp to W_C
- I_COL_VALID  in  1  array presents a column vector
- I_COL_DATA  in  ACC_W x [0:X_R-1]  column vector, element i = row i
- O_COL_READY  out  1  collector accepts a column this cycle
- O_Y_MATRIX  out  D_W x [0:X_R-1][0:W_C-1]  assembled requantized result
- O_BUSY  out  1  collection in progress
- O_DONE  out  1  one-cycle pulse, matrix complete
- O_SAT_FLAG  out  1  sticky: some element saturated during this collection

## Operation
- FSM states IDLE, COLLECT, DONE.
- IDLE: O_COL_READY=0, O_BUSY=0. I_START -> COLLECT (or DONE if clamped N_DIM==0); latch n = min(I_N_DIM, W_C), cnt=0, O_Y_MATRIX all 0, O_SAT_FLAG=0.
- COLLECT: O_COL_READY=1, O_BUSY=1. Handshake = I_COL_VALID & O_COL_READY. Columns arrive highest index first: handshake k stores column into O_Y_MATRIX[*][n-1-k]. On handshake with cnt==n-1 -> DONE; else cnt++.
- DONE: O_DONE=1 for exactly this cycle, O_BUSY=0, O_COL_READY=0; -> IDLE next cycle. Matrix held until next I_START.
- Columns n..W_C-1 remain 0.
- I_START in any state (including COLLECT mid-transfer, DONE) restarts as from IDLE; a handshake in the same cycle as I_START is discarded.
- I_COL_VALID outside COLLECT is ignored.
- Requantization per element: t = acc >>> SHIFT (arithmetic, floor); narrowing per Configuration.

## Timing
- Reset: state IDLE, cnt 0, O_Y_MATRIX all 0, O_COL_READY 0, O_BUSY 0, O_DONE 0, O_SAT_FLAG 0.
- O_COL_READY rises the cycle after I_START; a column accepted at edge t is visible on O_Y_MATRIX after edge t.
- Back-to-back: one column per cycle when I_COL_VALID held high; n columns -> O_DONE asserted the cycle after the n-th handshake edge; minimum start-to-done = n+1 cycles.
- N_DIM==0: O_DONE pulses the cycle after I_START, no handshakes.

## Configuration
- SA_COLLECT_SAT_EN defined: t outside [-2^(D_W-1), 2^(D_W-1)-1] clamps to the nearest bound and sets O_SAT_FLAG (sticky until I_START/reset).
- Undefined: result = t[D_W-1:0] (two's-complement wrap); O_SAT_FLAG tied 0.

## Structure
- Shared package (defines.v / sa_pkg): state enum {IDLE, COLLECT, DONE}, default widths D_W/ACC_W, saturation bound constants derived from D_W.
- Sub-module sa_quant: one element's shift + saturate/wrap, outputs value and sat bit; instanced X_R times.
- Top: FSM, column counter, matrix register file, write decode by column index.

## Test plan
- D_W=8, ACC_W=24, SHIFT=4, N_DIM=16, 16 back-to-back columns, column k all rows = 0x000123 -> O_Y_MATRIX every element 0x12, O_DONE one cycle at start+17.
- Element acc=4096 and acc=-4096 -> with SA_COLLECT_SAT_EN: 0x7F / 0x80, O_SAT_FLAG=1; without: 0x00 / 0x00, flag 0.
- N_DIM=3, columns A,B,C -> A at col 2, B col 1, C col 0; cols 3..15 = 0; O_DONE after 3rd handshake.
- I_COL_VALID toggled 1-0-1 with gaps, N_DIM=4 -> only valid cycles counted, done after 4th accept.
- I_START asserted after 5 of 16 columns -> matrix cleared, O_SAT_FLAG cleared, cnt restarts; 16 further columns required for O_DONE.
- I_N_DIM=0 -> O_DONE the cycle after I_START, O_COL_READY never high; I_N_DIM=200 -> clamps to 16 columns; I_RST mid-COLLECT -> all outputs reset values immediately.
